// File: rtl/alu_cmd_queue.sv
// Command-issue stage ahead of the 32-bit ALU: FIFO of (op, a, b), head presented to the ALU,
// result captured into a valid/ready output register with a sequence tag.
// Optional flag outputs (out_zero, out_neg) are enabled by defining ALU_CMD_QUEUE_FLAGS_EN.
module alu_cmd_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_m,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_op,
  output logic [SEQ_W-1:0] out_seq
`ifdef ALU_CMD_QUEUE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [SEQ_W-1:0] seq_q;
  logic             empty;
  logic             push;
  logic             issue;

  assign empty = (count == '0);
  assign push  = in_valid && in_ready;
  assign issue = !empty && (!out_valid || out_ready);
  assign head  = mem[rptr];

  // Head is only meaningful while occupied; zeros otherwise.
  assign alu_m = empty ? 4'b0 : head.op;
  assign alu_a = empty ? '0 : head.a;
  assign alu_b = empty ? '0 : head.b;

  always_comb begin
    count_nxt = count;
    if (push && !issue) begin
      count_nxt = count + CW'(1);
    end else if (!push && issue) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_op, in_a, in_b};
    end
  end

  // Pointers, occupancy and registered in_ready (from next occupancy, so no input-to-output path).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (issue) begin
        rptr <= rptr + AW'(1);
      end
      count    <= count_nxt;
      in_ready <= (count_nxt < CW'(DEPTH));
    end
  end

  // Result register: capture on issue, drop valid when consumed with nothing to replace it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      out_seq    <= '0;
      seq_q      <= '0;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
`endif
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_op     <= head.op;
      out_seq    <= seq_q;
      seq_q      <= seq_q + SEQ_W'(1);
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      out_zero   <= (alu_result == '0);
      out_neg    <= alu_result[WIDTH-1];
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_cmd_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } tcmd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [3:0]        alu_m;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_result;
  logic [3:0]        out_op;
  logic [SEQ_W-1:0]  out_seq;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
  logic              out_zero;
  logic              out_neg;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  tcmd_t       mq[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_result = '0;
  logic [3:0]  m_op = '0;
  logic [7:0]  m_seq = '0;
  int          m_seqc = 0;
  logic        m_zero = 1'b0;
  logic        m_neg = 1'b0;

  always #5 clk = ~clk;

  // External ALU behaviour
  function automatic logic [31:0] alu_f(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    case (m[2:0])
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return ~(a | b);
      3'd5:    return ~(a & b);
      3'd6:    return {31'b0, d[31] ^ m[3]};
      default: return d;
    endcase
  endfunction

  assign alu_result = alu_f(alu_m, alu_a, alu_b);

  alu_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .out_seq(out_seq)
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    , .out_zero(out_zero), .out_neg(out_neg)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model step on each active edge, from the inputs the DUT sees at that edge.
  always @(posedge clk) begin
    if (rst_n) begin
      tcmd_t h;
      logic  acc;
      logic  iss;
      acc = in_valid && (mq.size() < DEPTH);
      iss = (mq.size() > 0) && (!m_valid || out_ready);
      if (iss) begin
        h        = mq.pop_front();
        m_result = alu_f(h.op, h.a, h.b);
        m_op     = h.op;
        m_seq    = 8'(m_seqc);
        m_seqc   = (m_seqc + 1) % 256;
        m_valid  = 1'b1;
        m_zero   = (m_result == 32'd0);
        m_neg    = m_result[31];
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        h.op = in_op; h.a = in_a; h.b = in_b;
        mq.push_back(h);
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_result", 64'(out_result), 64'(m_result));
      chk("out_op", 64'(out_op), 64'(m_op));
      chk("out_seq", 64'(out_seq), 64'(m_seq));
      if (mq.size() > 0) begin
        chk("alu_m", 64'(alu_m), 64'(mq[0].op));
        chk("alu_a", 64'(alu_a), 64'(mq[0].a));
        chk("alu_b", 64'(alu_b), 64'(mq[0].b));
      end else begin
        chk("alu_m_empty", 64'(alu_m), 64'd0);
        chk("alu_a_empty", 64'(alu_a), 64'd0);
        chk("alu_b_empty", 64'(alu_b), 64'd0);
      end
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      chk("out_zero", 64'(out_zero), 64'(m_zero));
      chk("out_neg", 64'(out_neg), 64'(m_neg));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
  endtask

  // Asynchronous assert away from the edge, checked immediately; release one cycle later.
  task automatic do_reset();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    mq.delete();
    m_valid = 1'b0; m_result = '0; m_op = '0; m_seq = '0; m_seqc = 0; m_zero = 1'b0; m_neg = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_seq", 64'(out_seq), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    tick();
    do_reset();

    // ADD 5+7: two edges to out_valid, then consumed
    drive(1'b1, 4'b0011, 32'd5, 32'd7, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_result", 64'(out_result), 64'd12);
    chk("t1_op", 64'(out_op), 64'd3);
    chk("t1_seq", 64'(out_seq), 64'd0);
    tick();
    chk("t1_drop", 64'(out_valid), 64'd0);

    // SUB / set-less / inverted set-less, back to back
    do_reset();
    drive(1'b1, 4'b0111, 32'd3, 32'd5, 1'b1);
    tick();
    drive(1'b1, 4'b0110, 32'd3, 32'd5, 1'b1);
    tick();
    chk("t2_sub", 64'(out_result), 64'hFFFF_FFFE);
    chk("t2_seq0", 64'(out_seq), 64'd0);
    drive(1'b1, 4'b1110, 32'd3, 32'd5, 1'b1);
    tick();
    chk("t2_slt", 64'(out_result), 64'd1);
    chk("t2_seq1", 64'(out_seq), 64'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("t2_sltn", 64'(out_result), 64'd0);
    chk("t2_seq2", 64'(out_seq), 64'd2);
    chk("t2_valid", 64'(out_valid), 64'd1);

    // Fill with out_ready low: DEPTH + 1 accepted, then drain in order
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0011, $urandom, $urandom, 1'b0);
      if (in_ready) acc++;
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("t3_accepted", 64'(acc), 64'd5);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("t3_stall_seq", 64'(out_seq), 64'd0);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("t3_drain_valid", 64'(out_valid), 64'd1);
      chk("t3_drain_seq", 64'(out_seq), 64'(k));
    end
    tick();
    chk("t3_drained", 64'(out_valid), 64'd0);

    // Sequence wrap over 258 results
    do_reset();
    for (int i = 0; i < 258; i++) begin
      drive(1'b1, 4'b0011, 32'(i), 32'd1, 1'b1);
      tick();
      if (i > 0) begin
        chk("t4_seq", 64'(out_seq), 64'((i - 1) % 256));
        chk("t4_result", 64'(out_result), 64'(i));
      end
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("t4_seq_wrap", 64'(out_seq), 64'd1);

    // Reset with 3 queued and a pending result
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0011, 32'(i), 32'd9, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("t5_pending", 64'(out_valid), 64'd1);
    chk("t5_count", 64'(mq.size()), 64'd3);
    do_reset();
    drive(1'b1, 4'b0011, 32'd1, 32'd1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_seq", 64'(out_seq), 64'd0);
    chk("t5_result", 64'(out_result), 64'd2);

`ifdef ALU_CMD_QUEUE_FLAGS_EN
    do_reset();
    drive(1'b1, 4'b0010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    tick();
    drive(1'b1, 4'b0111, 32'd0, 32'd1, 1'b1);
    tick();
    chk("t6_zero", 64'(out_zero), 64'd1);
    chk("t6_nneg", 64'(out_neg), 64'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("t6_nzero", 64'(out_zero), 64'd0);
    chk("t6_neg", 64'(out_neg), 64'd1);
`endif

    // Randomized traffic with occasional mid-stream reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
            ($urandom_range(0, 2) != 0));
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
